// File: rtl/tanh_lut.sv
// tanh_lut: registered tanh activation, signed fixed-point in and out.
// A magnitude ROM covers [0, 4.0); negative inputs reuse it through odd
// symmetry and |x| >= 4.0 saturates to +/-1.0. One clock of latency.
module tanh_lut #(
   parameter int unsigned INPUT_WIDTH  = 16,
   parameter int unsigned OUTPUT_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH   = 9,
   parameter int unsigned FRAC_BITS    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [INPUT_WIDTH-1:0]  input_value,
   output logic                    out_valid,
   output logic [OUTPUT_WIDTH-1:0] tanh_out
);

   localparam int unsigned LUT_DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned ADDR_MSB   = FRAC_BITS + 1;
   localparam int unsigned ADDR_LSB   = FRAC_BITS + 2 - ADDR_WIDTH;
   // 2*x advances by 2^-STEP_SHIFT per ROM address (8.0 / 2^ADDR_WIDTH)
   localparam int unsigned STEP_SHIFT = ADDR_WIDTH - 3;
   // fixed-point precision of the elaboration-time exponential
   localparam int unsigned QF         = 30;
   localparam logic [INPUT_WIDTH-1:0]  SAT_LEVEL = INPUT_WIDTH'(4 << FRAC_BITS);
   localparam logic [OUTPUT_WIDTH-1:0] ONE       = OUTPUT_WIDTH'(1 << FRAC_BITS);

   // round(tanh(a * 4 / 2^ADDR_WIDTH) * 2^FRAC_BITS), evaluated at elaboration.
   // tanh(x) = (1 - u) / (1 + u) with u = exp(-2x) = exp(-2^-STEP_SHIFT)^a.
   function automatic int unsigned tanh_entry(input int unsigned a);
      longint          sum;
      longint          term;
      longint unsigned base;
      longint unsigned p;
      longint unsigned r;
      longint unsigned num;
      longint unsigned den;
      sum  = 64'sd0;
      term = 64'sd1 <<< 60;
      // Taylor series of exp(-2^-STEP_SHIFT) in Q60
      for (int n = 0; n < 16; n++) begin
         if ((n % 2) == 0) sum = sum + term;
         else              sum = sum - term;
         term = term / (longint'(n + 1) <<< STEP_SHIFT);
      end
      base = 64'(sum >>> (60 - QF));
      // square-and-multiply for base^a in Q30
      r = 64'd1 << QF;
      p = base;
      for (int unsigned j = 0; j < ADDR_WIDTH; j++) begin
         if (a[j]) r = (r * p + (64'd1 << (QF - 1))) >> QF;
         p = (p * p + (64'd1 << (QF - 1))) >> QF;
      end
      num = (64'd1 << QF) - r;
      den = (64'd1 << QF) + r;
      return 32'((num * (64'd1 << (FRAC_BITS + 1)) + den) / (den << 1));
   endfunction

   logic [OUTPUT_WIDTH-1:0] w_lut [LUT_DEPTH];

   // constant magnitude ROM
   for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
      localparam int unsigned ENTRY = tanh_entry(g);
      assign w_lut[g] = OUTPUT_WIDTH'(ENTRY);
   end

   logic                    w_sign;
   logic [INPUT_WIDTH-1:0]  w_mag;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [OUTPUT_WIDTH-1:0] w_mag_res;
   logic [OUTPUT_WIDTH-1:0] w_result;

   // abs, saturate/lookup, restore sign; 0x8000 stays 0x8000 as unsigned
   // magnitude and therefore saturates
   always_comb begin
      w_sign    = input_value[INPUT_WIDTH-1];
      w_mag     = w_sign ? (~input_value + INPUT_WIDTH'(1)) : input_value;
      w_addr    = w_mag[ADDR_MSB:ADDR_LSB];
      w_mag_res = (w_mag >= SAT_LEVEL) ? ONE : w_lut[w_addr];
      w_result  = w_sign ? (~w_mag_res + OUTPUT_WIDTH'(1)) : w_mag_res;
   end

   logic                    r_valid;
   logic [OUTPUT_WIDTH-1:0] r_tanh;

   // output register: data loads only on valid, flag follows in_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_tanh  <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) r_tanh <= w_result;
      end
   end

   assign out_valid = r_valid;
   assign tanh_out  = r_tanh;

endmodule

// File: tb/tb_tanh_lut.sv
// tb_tanh_lut: directed vectors, sweep with symmetry/monotonic/tolerance
// checks, reset and valid-gating behaviour.
module tb_tanh_lut;

   localparam int unsigned W = 16;
   localparam int unsigned NDIR = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] input_value;
   logic         out_valid;
   logic [W-1:0] tanh_out;

   int n_tests = 0;
   int n_fail  = 0;

   tanh_lut #(
      .INPUT_WIDTH (16),
      .OUTPUT_WIDTH(16),
      .ADDR_WIDTH  (9),
      .FRAC_BITS   (8)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .input_value(input_value),
      .out_valid  (out_valid),
      .tanh_out   (tanh_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // drive one input for one edge, then sample just after that edge
   task automatic step(input logic v, input logic [W-1:0] x);
      @(negedge clk);
      in_valid    = v;
      input_value = x;
      @(posedge clk);
      #1;
   endtask

   function automatic int model_q(input int x);
      real r;
      r = $tanh(real'(x) / 256.0) * 256.0;
      if (r >= 0.0) return $rtoi($floor(r + 0.5));
      else          return -$rtoi($floor(-r + 0.5));
   endfunction

   logic [W-1:0] dir_in  [NDIR];
   logic [W-1:0] dir_exp [NDIR];
   int           pos_o   [32];
   int           neg_o   [32];
   int           x;
   int           d;

   initial begin
      dir_in  = '{16'h0000, 16'h0021, 16'hFFDF, 16'h0100, 16'hFF00, 16'h0200,
                  16'hFE00, 16'h0400, 16'hFC00, 16'h7FFF, 16'h8000, 16'h0080,
                  16'h0101, 16'hFFFF, 16'h03FF, 16'hFC01};
      dir_exp = '{16'h0000, 16'h0020, 16'hFFE0, 16'h00C3, 16'hFF3D, 16'h00F7,
                  16'hFF09, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0076,
                  16'h00C3, 16'h0000, 16'h0100, 16'hFF00};

      // reset at time zero, checked before any clock edge
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      input_value = '0;
      #2;
      check("rst_data", tanh_out, 16'h0000);
      check("rst_vld", W'(out_valid), W'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 16'h1234);
      step(1'b0, 16'h1234);
      check("idle_data", tanh_out, 16'h0000);
      check("idle_vld", W'(out_valid), W'(1'b0));

      // directed vectors, one cycle of latency each
      for (int i = 0; i < int'(NDIR); i++) begin
         step(1'b1, dir_in[i]);
         check($sformatf("dir_%04h", dir_in[i]), tanh_out, dir_exp[i]);
         check("dir_vld", W'(out_valid), W'(1'b1));
      end

      // back-to-back sweep, negative then positive per magnitude
      for (int i = 0; i < 32; i++) begin
         x = (1024 * i) / 31;
         step(1'b1, W'(-x));
         neg_o[i] = int'($signed(tanh_out));
         check("sweep_vld_n", W'(out_valid), W'(1'b1));
         d = neg_o[i] - model_q(-x);
         check($sformatf("sweep_tol_n%0d", i), W'((d <= 1) && (d >= -1)), W'(1'b1));
         step(1'b1, W'(x));
         pos_o[i] = int'($signed(tanh_out));
         check("sweep_vld_p", W'(out_valid), W'(1'b1));
         d = pos_o[i] - model_q(x);
         check($sformatf("sweep_tol_p%0d", i), W'((d <= 1) && (d >= -1)), W'(1'b1));
         check($sformatf("sweep_sym%0d", i), W'(neg_o[i]), W'(-pos_o[i]));
         if (i > 0) begin
            check($sformatf("sweep_mono_p%0d", i), W'(pos_o[i] >= pos_o[i-1]), W'(1'b1));
            check($sformatf("sweep_mono_n%0d", i), W'(neg_o[i] <= neg_o[i-1]), W'(1'b1));
         end
      end
      check("sweep_top", W'(pos_o[31]), 16'h0100);

      // valid gating: one pulse, then idle with held data
      step(1'b1, 16'h0100);
      check("pulse_data", tanh_out, 16'h00C3);
      check("pulse_vld", W'(out_valid), W'(1'b1));
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 16'h0400);
         check("hold_data", tanh_out, 16'h00C3);
         check("hold_vld", W'(out_valid), W'(1'b0));
      end

      // asynchronous reset mid-stream, mid-cycle
      step(1'b1, 16'hFE00);
      check("pre_rst", tanh_out, 16'hFF09);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_data", tanh_out, 16'h0000);
      check("async_rst_vld", W'(out_valid), W'(1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_data", tanh_out, 16'h0000);
      check("post_rst_vld", W'(out_valid), W'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
